// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES mode sequencer.
//   AES_BLK_W  : width of one AES block / key
//   aes_mode_e : chaining mode as held in the job registers
//   ST_*       : FSM state encodings for aes_mode_ctrl
//   ctr_inc32  : CTR increment on the low 32-bit word only
package aes_ctrl_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [1:0] {
        MODE_ECB = 2'd0,
        MODE_CBC = 2'd1,
        MODE_CTR = 2'd2
    } aes_mode_e;

    // State enumeration, kept as plain constants for legacy tool flows.
    typedef logic [2:0] aes_state_t;

    localparam aes_state_t ST_IDLE    = 3'd0;
    localparam aes_state_t ST_KEYLOAD = 3'd1;
    localparam aes_state_t ST_KEYWAIT = 3'd2;
    localparam aes_state_t ST_FETCH   = 3'd3;
    localparam aes_state_t ST_ISSUE   = 3'd4;
    localparam aes_state_t ST_WAIT    = 3'd5;
    localparam aes_state_t ST_OUT     = 3'd6;
    localparam aes_state_t ST_FIN     = 3'd7;

    // Low word wraps modulo 2^32; the upper 96 bits never see a carry.
    function automatic logic [AES_BLK_W-1:0] ctr_inc32(input logic [AES_BLK_W-1:0] c);
        return {c[AES_BLK_W-1:32], c[31:0] + 32'd1};
    endfunction

endpackage

// File: rtl/aes_mode_xform.sv
// Per-mode XOR selection around the AES core. One instance sits on the
// input side (block -> core input), one on the output side (core result ->
// stream output).
//   OUT_SIDE  : 0 = input side, 1 = output side
//   mode_i    : latched chaining mode
//   decrypt_i : latched direction
//   data_i    : s_data (input side) or core result (output side)
//   chain_i   : CBC chaining value
//   alt_i     : CTR counter block (input side) or saved input block (output side)
//   data_o    : transformed block
module aes_mode_xform
    import aes_ctrl_pkg::*;
#(
    parameter bit OUT_SIDE = 1'b0
) (
    input  aes_mode_e              mode_i,
    input  logic                   decrypt_i,
    input  logic [AES_BLK_W-1:0]   data_i,
    input  logic [AES_BLK_W-1:0]   chain_i,
    input  logic [AES_BLK_W-1:0]   alt_i,
    output logic [AES_BLK_W-1:0]   data_o
);

    always_comb begin
        data_o = data_i;
        unique case (mode_i)
            MODE_CBC: begin
                // Encrypt XORs the chain before the core, decrypt after it.
                if (decrypt_i == OUT_SIDE) begin
                    data_o = data_i ^ chain_i;
                end
            end
            MODE_CTR: begin
                // Core encrypts the counter; keystream is XORed with the saved block.
                data_o = OUT_SIDE ? (data_i ^ alt_i) : alt_i;
            end
            default: begin
                data_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/aes_mode_ctrl.sv
// Multi-block ECB/CBC/CTR job sequencer in front of an AES-128 core.
// Loads the key once per job, then pushes one block at a time through the
// core, applying chaining on both sides. Only one block is ever in flight.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   cfg_*                   : job configuration, latched on cfg_start_i in idle
//   busy_o, done_o          : job in progress / one-cycle end-of-job pulse
//   s_valid_i/s_ready_o/s_data_i           : input block stream
//   m_valid_o/m_ready_i/m_data_o/m_last_o  : output block stream
//   core_*                  : connection to the AES core
module aes_mode_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned KEY_LOAD_CYCLES = 2,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cfg_start_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic                   cfg_decrypt_i,
    input  logic [AES_BLK_W-1:0]   cfg_key_i,
    input  logic [AES_BLK_W-1:0]   cfg_iv_i,
    input  logic [CNT_W-1:0]       cfg_nblocks_i,
    output logic                   busy_o,
    output logic                   done_o,

    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [AES_BLK_W-1:0]   s_data_i,

    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [AES_BLK_W-1:0]   m_data_o,
    output logic                   m_last_o,

    output logic                   core_load_key_o,
    output logic [AES_BLK_W-1:0]   core_key_o,
    output logic                   core_decrypt_o,
    output logic                   core_in_valid_o,
    input  logic                   core_in_ready_i,
    output logic [AES_BLK_W-1:0]   core_in_data_o,
    input  logic [AES_BLK_W-1:0]   core_out_data_i,
    input  logic                   core_out_valid_i
);

    localparam int unsigned LC_W = (KEY_LOAD_CYCLES > 1) ? $clog2(KEY_LOAD_CYCLES) : 1;

    aes_state_t              state_q, state_d;
    aes_mode_e               mode_q, mode_d;
    logic                    decrypt_q, decrypt_d;
    logic [AES_BLK_W-1:0]    key_q, key_d;
    logic [AES_BLK_W-1:0]    chain_q, chain_d;
    logic [AES_BLK_W-1:0]    ctr_q, ctr_d;
    logic [CNT_W-1:0]        nblocks_q, nblocks_d;
    logic [CNT_W-1:0]        blk_cnt_q, blk_cnt_d;
    logic [LC_W-1:0]         load_cnt_q, load_cnt_d;
    logic [AES_BLK_W-1:0]    in_q, in_d;
    logic [AES_BLK_W-1:0]    core_in_data_q, core_in_data_d;
    logic [AES_BLK_W-1:0]    m_data_q, m_data_d;

    logic [AES_BLK_W-1:0]    pre_data;
    logic [AES_BLK_W-1:0]    post_data;
    logic                    last_blk;

    aes_mode_xform #(
        .OUT_SIDE (1'b0)
    ) u_pre_xform (
        .mode_i    (mode_q),
        .decrypt_i (decrypt_q),
        .data_i    (s_data_i),
        .chain_i   (chain_q),
        .alt_i     (ctr_q),
        .data_o    (pre_data)
    );

    aes_mode_xform #(
        .OUT_SIDE (1'b1)
    ) u_post_xform (
        .mode_i    (mode_q),
        .decrypt_i (decrypt_q),
        .data_i    (core_out_data_i),
        .chain_i   (chain_q),
        .alt_i     (in_q),
        .data_o    (post_data)
    );

    // nblocks_q is never 0 while a block is in OUT, so the subtraction cannot wrap there.
    assign last_blk = (blk_cnt_q == (nblocks_q - 1'b1));

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        decrypt_d      = decrypt_q;
        key_d          = key_q;
        chain_d        = chain_q;
        ctr_d          = ctr_q;
        nblocks_d      = nblocks_q;
        blk_cnt_d      = blk_cnt_q;
        load_cnt_d     = load_cnt_q;
        in_d           = in_q;
        core_in_data_d = core_in_data_q;
        m_data_d       = m_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    case (cfg_mode_i)
                        2'd1:    mode_d = MODE_CBC;
                        2'd2:    mode_d = MODE_CTR;
                        default: mode_d = MODE_ECB;
                    endcase
                    decrypt_d  = cfg_decrypt_i;
                    key_d      = cfg_key_i;
                    chain_d    = cfg_iv_i;
                    ctr_d      = cfg_iv_i;
                    nblocks_d  = cfg_nblocks_i;
                    blk_cnt_d  = '0;
                    load_cnt_d = '0;
                    state_d    = (cfg_nblocks_i != '0) ? ST_KEYLOAD : ST_FIN;
                end
            end
            ST_KEYLOAD: begin
                if (load_cnt_q == LC_W'(KEY_LOAD_CYCLES - 1)) begin
                    state_d = ST_KEYWAIT;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            ST_KEYWAIT: begin
                if (core_in_ready_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (s_valid_i) begin
                    in_d           = s_data_i;
                    core_in_data_d = pre_data;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_in_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_out_valid_i) begin
                    m_data_d = post_data;
                    if (mode_q == MODE_CBC) begin
                        chain_d = decrypt_q ? in_q : core_out_data_i;
                    end
                    if (mode_q == MODE_CTR) begin
                        ctr_d = ctr_inc32(ctr_q);
                    end
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready_i) begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                    state_d   = last_blk ? ST_FIN : ST_FETCH;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_ECB;
            decrypt_q      <= 1'b0;
            key_q          <= '0;
            chain_q        <= '0;
            ctr_q          <= '0;
            nblocks_q      <= '0;
            blk_cnt_q      <= '0;
            load_cnt_q     <= '0;
            in_q           <= '0;
            core_in_data_q <= '0;
            m_data_q       <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            decrypt_q      <= decrypt_d;
            key_q          <= key_d;
            chain_q        <= chain_d;
            ctr_q          <= ctr_d;
            nblocks_q      <= nblocks_d;
            blk_cnt_q      <= blk_cnt_d;
            load_cnt_q     <= load_cnt_d;
            in_q           <= in_d;
            core_in_data_q <= core_in_data_d;
            m_data_q       <= m_data_d;
        end
    end

    // All handshake outputs decode straight from the state register, so an
    // asynchronous reset clears them without waiting for a clock.
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_FIN);
    assign s_ready_o       = (state_q == ST_FETCH);
    assign core_load_key_o = (state_q == ST_KEYLOAD);
    assign core_in_valid_o = (state_q == ST_ISSUE);
    assign m_valid_o       = (state_q == ST_OUT);
    assign m_last_o        = (state_q == ST_OUT) && last_blk;
    assign m_data_o        = m_data_q;
    assign core_in_data_o  = core_in_data_q;
    assign core_key_o      = key_q;
    // CTR only ever runs the core forwards.
    assign core_decrypt_o  = decrypt_q && (mode_q != MODE_CTR);

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Self-checking bench for aes_mode_ctrl. A behavioural stand-in for the AES
// core answers each core input from a lookup table of known AES results
// (bitwise inverse of the input when the table has no entry).
module tb_aes_mode_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         cfg_start_i;
    logic [1:0]   cfg_mode_i;
    logic         cfg_decrypt_i;
    logic [127:0] cfg_key_i;
    logic [127:0] cfg_iv_i;
    logic [15:0]  cfg_nblocks_i;
    logic         busy_o;
    logic         done_o;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [127:0] s_data_i;
    logic         m_valid_o;
    logic         m_ready_i;
    logic [127:0] m_data_o;
    logic         m_last_o;
    logic         core_load_key_o;
    logic [127:0] core_key_o;
    logic         core_decrypt_o;
    logic         core_in_valid_o;
    logic         core_in_ready_i;
    logic [127:0] core_in_data_o;
    logic [127:0] core_out_data_i;
    logic         core_out_valid_i;

    aes_mode_ctrl #(
        .KEY_LOAD_CYCLES (2),
        .CNT_W           (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_mode_i       (cfg_mode_i),
        .cfg_decrypt_i    (cfg_decrypt_i),
        .cfg_key_i        (cfg_key_i),
        .cfg_iv_i         (cfg_iv_i),
        .cfg_nblocks_i    (cfg_nblocks_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .s_valid_i        (s_valid_i),
        .s_ready_o        (s_ready_o),
        .s_data_i         (s_data_i),
        .m_valid_o        (m_valid_o),
        .m_ready_i        (m_ready_i),
        .m_data_o         (m_data_o),
        .m_last_o         (m_last_o),
        .core_load_key_o  (core_load_key_o),
        .core_key_o       (core_key_o),
        .core_decrypt_o   (core_decrypt_o),
        .core_in_valid_o  (core_in_valid_o),
        .core_in_ready_i  (core_in_ready_i),
        .core_in_data_o   (core_in_data_o),
        .core_out_data_i  (core_out_data_i),
        .core_out_valid_i (core_out_valid_i)
    );

    localparam logic [127:0] K    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] X2   = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] C2   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CTR0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CTR1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] KS1  = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] CT1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P3   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] WIV  = 128'h0123456789abcdef01234567ffffffff;
    localparam logic [127:0] WIV1 = 128'h0123456789abcdef0123456700000000;
    localparam logic [127:0] NONE = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- behavioural core + monitors ----------------
    logic [127:0] resp_tab [logic [127:0]];
    logic [127:0] cin_log [$];
    logic [127:0] ckey_log [$];
    logic         cdec_log [$];
    int           core_lat;
    int           lk_cnt   = 0;
    int           done_cnt = 0;
    int           srdy_cnt = 0;
    int           cval_cnt = 0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_out_valid_i <= 1'b0;
            core_out_data_i  <= '0;
            core_lat         <= -1;
        end else begin
            core_out_valid_i <= 1'b0;
            if (core_in_valid_o && core_in_ready_i) begin
                cin_log.push_back(core_in_data_o);
                ckey_log.push_back(core_key_o);
                cdec_log.push_back(core_decrypt_o);
                core_lat <= 2;
            end else if (core_lat > 0) begin
                core_lat <= core_lat - 1;
            end else if (core_lat == 0) begin
                core_out_valid_i <= 1'b1;
                core_out_data_i  <= resp_tab.exists(cin_log[cin_log.size()-1]) ?
                                    resp_tab[cin_log[cin_log.size()-1]] :
                                    ~cin_log[cin_log.size()-1];
                core_lat <= -1;
            end
        end
    end

    always @(posedge clk_i) begin
        if (core_load_key_o) lk_cnt   <= lk_cnt + 1;
        if (done_o)          done_cnt <= done_cnt + 1;
        if (s_ready_o)       srdy_cnt <= srdy_cnt + 1;
        if (core_in_valid_o) cval_cnt <= cval_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] cin_at(input int i);
        if (i < cin_log.size()) return cin_log[i];
        return NONE;
    endfunction

    function automatic logic [127:0] ckey_at(input int i);
        if (i < ckey_log.size()) return ckey_log[i];
        return NONE;
    endfunction

    function automatic logic cdec_at(input int i);
        if (i < cdec_log.size()) return cdec_log[i];
        return 1'bx;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"}, {120'd0, busy_o, done_o, s_ready_o, m_valid_o, m_last_o,
                            core_load_key_o, core_decrypt_o, core_in_valid_o}, '0);
        chk({tag, " m_data"}, m_data_o, '0);
        chk({tag, " core_in_data"}, core_in_data_o, '0);
        chk({tag, " core_key"}, core_key_o, '0);
    endtask

    // ---------------- job driver ----------------
    logic [127:0] pt_arr   [0:3];
    logic [127:0] out_arr  [0:3];
    logic         last_arr [0:3];
    int           cin_base;
    int           lk_diff;
    int           dn_diff;
    int           early;

    task automatic run_job(input logic [1:0] mode, input logic dec, input logic [127:0] key,
                           input logic [127:0] iv, input int nb, input int ready_hold,
                           input int stall, input bit poke);
        int lk0;
        int dn0;
        int bad;
        logic [127:0] held;
        lk0      = lk_cnt;
        dn0      = done_cnt;
        early    = 0;
        cin_base = cin_log.size();
        for (int i = 0; i < 4; i++) begin
            out_arr[i]  = NONE;
            last_arr[i] = 1'bx;
        end
        @(negedge clk_i);
        cfg_start_i   = 1'b1;
        cfg_mode_i    = mode;
        cfg_decrypt_i = dec;
        cfg_key_i     = key;
        cfg_iv_i      = iv;
        cfg_nblocks_i = 16'(nb);
        if (ready_hold > 0) core_in_ready_i = 1'b0;
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        for (int h = 0; h < ready_hold; h++) begin
            if (core_in_valid_o) early++;
            @(negedge clk_i);
        end
        core_in_ready_i = 1'b1;
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 100 && !s_ready_o; t++) @(negedge clk_i);
            if (!s_ready_o) begin
                chk("s_ready timeout", {127'd0, s_ready_o}, 128'd1);
                return;
            end
            s_valid_i = 1'b1;
            s_data_i  = pt_arr[b];
            if (poke && b == 0) begin
                cfg_start_i   = 1'b1;
                cfg_mode_i    = 2'd2;
                cfg_key_i     = ~key;
                cfg_iv_i      = ~iv;
                cfg_nblocks_i = 16'd5;
            end
            @(negedge clk_i);
            s_valid_i   = 1'b0;
            cfg_start_i = 1'b0;
            for (int t = 0; t < 100 && !m_valid_o; t++) @(negedge clk_i);
            if (!m_valid_o) begin
                chk("m_valid timeout", {127'd0, m_valid_o}, 128'd1);
                return;
            end
            out_arr[b]  = m_data_o;
            last_arr[b] = m_last_o;
            if (stall > 0 && b == 0) begin
                held = m_data_o;
                bad  = 0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk_i);
                    if (m_data_o !== held || !m_valid_o || s_ready_o) bad++;
                end
                chk("stall stable", 128'(bad), 128'd0);
            end
            m_ready_i = 1'b1;
            @(negedge clk_i);
            m_ready_i = 1'b0;
        end
        for (int t = 0; t < 10 && !done_o; t++) @(negedge clk_i);
        if (!done_o) chk("done timeout", {127'd0, done_o}, 128'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        lk_diff = lk_cnt - lk0;
        dn_diff = done_cnt - dn0;
    endtask

    // ---------------- single-block vector table ----------------
    typedef struct {
        string        name;
        logic [1:0]   mode;
        logic         dec;
        logic [127:0] iv;
        logic [127:0] pt;
        logic [127:0] exp_in;
        logic [127:0] exp_out;
        logic         exp_cdec;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int first;
        int s0;
        int c0;
        int l0;
        int d0;

        rst_i           = 1'b1;
        cfg_start_i     = 1'b0;
        cfg_mode_i      = 2'd0;
        cfg_decrypt_i   = 1'b0;
        cfg_key_i       = '0;
        cfg_iv_i        = '0;
        cfg_nblocks_i   = '0;
        s_valid_i       = 1'b0;
        s_data_i        = '0;
        m_ready_i       = 1'b0;
        core_in_ready_i = 1'b1;

        resp_tab[P1]   = C1;
        resp_tab[C1]   = P1;
        resp_tab[X2]   = C2;
        resp_tab[C2]   = X2;
        resp_tab[P2]   = C2;
        resp_tab[CTR0] = KS1;

        vecs[0] = '{"ecb_enc",  2'd0, 1'b0, '0,   P1, P1,   C1,  1'b0};
        vecs[1] = '{"cbc_enc",  2'd1, 1'b0, IV,   P2, X2,   C2,  1'b0};
        vecs[2] = '{"cbc_dec",  2'd1, 1'b1, IV,   C2, C2,   P2,  1'b1};
        vecs[3] = '{"ctr",      2'd2, 1'b1, CTR0, P2, CTR0, CT1, 1'b0};
        vecs[4] = '{"mode3",    2'd3, 1'b0, IV,   P2, P2,   C2,  1'b0};
        vecs[5] = '{"ecb_dec",  2'd0, 1'b1, IV,   C1, C1,   P1,  1'b1};

        repeat (3) @(negedge clk_i);
        chk_all_zero("in_reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_all_zero("after_reset");

        foreach (vecs[v]) begin
            pt_arr[0] = vecs[v].pt;
            run_job(vecs[v].mode, vecs[v].dec, K, vecs[v].iv, 1, 4, 0, 1'b0);
            chk({vecs[v].name, " early_valid"}, 128'(early), 128'd0);
            chk({vecs[v].name, " n_core"}, 128'(cin_log.size() - cin_base), 128'd1);
            chk({vecs[v].name, " core_in"}, cin_at(cin_base), vecs[v].exp_in);
            chk({vecs[v].name, " core_key"}, ckey_at(cin_base), K);
            chk({vecs[v].name, " core_dec"}, {127'd0, cdec_at(cin_base)}, {127'd0, vecs[v].exp_cdec});
            chk({vecs[v].name, " m_data"}, out_arr[0], vecs[v].exp_out);
            chk({vecs[v].name, " m_last"}, {127'd0, last_arr[0]}, 128'd1);
            chk({vecs[v].name, " keyload"}, 128'(lk_diff), 128'd2);
            chk({vecs[v].name, " done"}, 128'(dn_diff), 128'd1);
        end

        // CTR two blocks: counter steps in the low word, key loaded once.
        pt_arr[0] = P2;
        pt_arr[1] = P3;
        run_job(2'd2, 1'b0, K, CTR0, 2, 0, 0, 1'b0);
        chk("ctr2 in0", cin_at(cin_base), CTR0);
        chk("ctr2 in1", cin_at(cin_base + 1), CTR1);
        chk("ctr2 out0", out_arr[0], CT1);
        chk("ctr2 out1", out_arr[1], P3 ^ ~CTR1);
        chk("ctr2 last", {126'd0, last_arr[0], last_arr[1]}, 128'd1);
        chk("ctr2 keyload", 128'(lk_diff), 128'd2);

        // CTR low-word wrap.
        pt_arr[0] = P1;
        pt_arr[1] = P2;
        run_job(2'd2, 1'b0, K, WIV, 2, 0, 0, 1'b0);
        chk("wrap in0", cin_at(cin_base), WIV);
        chk("wrap in1", cin_at(cin_base + 1), WIV1);

        // CBC encrypt chaining across two blocks.
        pt_arr[0] = P2;
        pt_arr[1] = P3;
        run_job(2'd1, 1'b0, K, IV, 2, 0, 0, 1'b0);
        chk("cbce2 in1", cin_at(cin_base + 1), P3 ^ C2);
        chk("cbce2 out1", out_arr[1], ~(P3 ^ C2));

        // CBC decrypt chaining across two blocks.
        pt_arr[0] = C2;
        pt_arr[1] = P3;
        run_job(2'd1, 1'b1, K, IV, 2, 0, 0, 1'b0);
        chk("cbcd2 out0", out_arr[0], P2);
        chk("cbcd2 in1", cin_at(cin_base + 1), P3);
        chk("cbcd2 out1", out_arr[1], ~P3 ^ C2);

        // nblocks = 0: straight to FIN, nothing touches the core or stream.
        s0 = srdy_cnt;
        c0 = cval_cnt;
        l0 = lk_cnt;
        d0 = done_cnt;
        first = -1;
        @(negedge clk_i);
        cfg_start_i   = 1'b1;
        cfg_mode_i    = 2'd0;
        cfg_nblocks_i = 16'd0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            cfg_start_i = 1'b0;
            if (done_o && first < 0) first = i;
        end
        chk("nb0 done timing", {127'd0, (first >= 1 && first <= 2)}, 128'd1);
        chk("nb0 done count", 128'(done_cnt - d0), 128'd1);
        chk("nb0 s_ready", 128'(srdy_cnt - s0), 128'd0);
        chk("nb0 core_valid", 128'(cval_cnt - c0), 128'd0);
        chk("nb0 keyload", 128'(lk_cnt - l0), 128'd0);

        // Output stall of 10 cycles.
        pt_arr[0] = P1;
        pt_arr[1] = P2;
        run_job(2'd0, 1'b0, K, '0, 2, 0, 10, 1'b0);
        chk("stall out0", out_arr[0], C1);
        chk("stall out1", out_arr[1], C2);

        // Start while busy is ignored.
        pt_arr[0] = P1;
        run_job(2'd0, 1'b0, K, '0, 1, 0, 0, 1'b1);
        chk("poke out", out_arr[0], C1);
        chk("poke key", ckey_at(cin_base), K);
        chk("poke done", 128'(dn_diff), 128'd1);
        chk("poke idle", {127'd0, busy_o}, 128'd0);

        // Reset in ISSUE clears everything without a clock edge.
        @(negedge clk_i);
        cfg_start_i   = 1'b1;
        cfg_mode_i    = 2'd0;
        cfg_decrypt_i = 1'b0;
        cfg_key_i     = K;
        cfg_nblocks_i = 16'd1;
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        for (int t = 0; t < 50 && !s_ready_o; t++) @(negedge clk_i);
        core_in_ready_i = 1'b0;
        s_valid_i       = 1'b1;
        s_data_i        = P1;
        @(negedge clk_i);
        s_valid_i = 1'b0;
        chk("issue valid", {127'd0, core_in_valid_o}, 128'd1);
        #2 rst_i = 1'b1;
        #1 chk_all_zero("mid_reset");
        @(negedge clk_i);
        rst_i           = 1'b0;
        core_in_ready_i = 1'b1;
        @(negedge clk_i);
        chk("post_reset valid", {126'd0, core_in_valid_o, busy_o}, 128'd0);

        pt_arr[0] = P1;
        run_job(2'd0, 1'b0, K, '0, 1, 0, 0, 1'b0);
        chk("reload keyload", 128'(lk_diff), 128'd2);
        chk("reload out", out_arr[0], C1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
Sequencer in front of AES_top_mod that runs multi-block ECB, CBC and CTR jobs. It issues the key load, then streams blocks one at a time through the core. For each block it applies the chaining XOR or counter on the input and output sides. It has one block in flight, because CBC needs the previous result and the core output has no backpressure.

Parameters:
KEY_LOAD_CYCLES, 2, cycles core_load_key_o is held high per job (min 1)
CNT_W, 16, width of block-count field

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cfg_start_i  in  1  start-job pulse; ignored unless idle
cfg_mode_i  in  2  0=ECB 1=CBC 2=CTR (3 treated as ECB)
cfg_decrypt_i  in  1  decrypt direction (ECB/CBC only)
cfg_key_i  in  128  AES-128 key
cfg_iv_i  in  128  CBC IV / CTR initial counter block
cfg_nblocks_i  in  CNT_W  blocks in job
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at job end
s_valid_i  in  1  input block valid
s_ready_o  out  1  input block accepted
s_data_i  in  128  input block
m_valid_o  out  1  output block valid
m_ready_i  in  1  output accepted
m_data_o  out  128  output block
m_last_o  out  1  final block of job
core_load_key_o  out  1  to load_key_i
core_key_o  out  128  to key_i
core_decrypt_o  out  1  to decrypt_i
core_in_valid_o  out  1  to indata_valid_i
core_in_ready_i  in  1  from indata_ready_o
core_in_data_o  out  128  to indata_i
core_out_data_i  in  128  from outdata_o
core_out_valid_i  in  1  from outdata_valid_o (single-cycle pulse)

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: state=IDLE. All outputs 0, including the data buses. Registered cfg, chain, counter and saved-input registers are 0.
- Latched at start: on cfg_start_i in IDLE, latch mode, decrypt, key, iv→chain/ctr and nblocks, and clear blk_cnt. Start while busy is ignored.
- Core outputs during a job: core_key_o holds the latched key. core_decrypt_o = decrypt && mode!=CTR, because CTR always encrypts.
- State IDLE: on start, go to KEYLOAD if nblocks!=0. If nblocks==0, go to FIN with no core or stream activity.
- State KEYLOAD: core_load_key_o=1 for exactly KEY_LOAD_CYCLES cycles, then KEYWAIT.
- State KEYWAIT: wait for core_in_ready_i=1, then FETCH.
- State FETCH: s_ready_o=1. On s_valid_i&&s_ready_o, capture s_data_i into in_q, compute core input, go to ISSUE. s_ready_o is low in every other state.
- Core input by mode:
  - ECB: s_data.
  - CBC encrypt: s_data^chain.
  - CBC decrypt: s_data.
  - CTR: ctr.
- State ISSUE: core_in_valid_o=1 with core_in_data_o stable until the rising edge where core_in_ready_i=1, then go to WAIT. Valid must never drop before the transfer.
- State WAIT: on core_out_valid_i, register the result into m_data_o and go to OUT.
- Result by mode:
  - ECB: out.
  - CBC encrypt: out; chain←out.
  - CBC decrypt: out^chain; chain←in_q.
  - CTR: out^in_q; ctr[31:0]←ctr[31:0]+1 mod 2^32, ctr[127:32] unchanged (no carry out).
- State OUT: m_valid_o=1 and m_data_o/m_last_o stable until m_ready_i. m_last_o = (blk_cnt==nblocks-1). On acceptance, blk_cnt++. If this was the last block go to FIN, else go to FETCH. No KEYLOAD between blocks.
- State FIN: done_o=1 for one cycle, then IDLE.
- busy_o: 1 in every state except IDLE.
- Core output outside WAIT: a core_out_valid_i pulse in any other state is ignored (protocol error, no state change).
- Latency per block: 1 (FETCH) + core handshake + core latency + 1 (register) + output stall.
- Reset mid-job: immediate return to IDLE. Outputs go to reset values, including a deasserted core_in_valid_o. The next job reloads the key.

Decomposition:
- Package aes_ctrl_pkg holds:
  - mode enum (MODE_ECB, MODE_CBC, MODE_CTR);
  - state enum;
  - constant AES_BLK_W=128;
  - function ctr_inc32().
- Sub-module aes_mode_xform: combinational pre- and post-XOR selection per mode and direction, reused for the input and output paths. The FSM, counters and registers stay in aes_mode_ctrl.

Test Plan:
- Key load count: any job → core_load_key_o high exactly KEY_LOAD_CYCLES cycles per job, no core_in_valid_o before core_in_ready_i.
- ECB encrypt, 1 block: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → m_data 3925841d02dc09fbdc118597196a0b32, m_last=1, done_o pulses once.
- CBC encrypt: IV 000102030405060708090a0b0c0d0e0f, pt 6bc1bee22e409f96e93d7e117393172a, same key → 7649abac8119b246cee98e9b12e9197d.
- CBC decrypt: feed that ciphertext back with the same IV → original pt.
- CTR encrypt: ctr f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, pt 6bc1bee22e409f96e93d7e117393172a → 874d6191b620e3261bef6864990db6ce; second block core input ends fcfdff00.
- CTR low-word wrap: iv low word ffffffff, 2 blocks → 2nd core input low word 00000000, upper 96 bits unchanged.
- Boundaries:
  - nblocks=0 → done_o two cycles after start, no s_ready_o or core activity.
  - m_ready_i held low 10 cycles → m_data_o stable, no new s_ready_o.
  - start while busy → ignored.
  - rst_i mid-ISSUE → all outputs 0 asynchronously.
